// File: rtl/vga_capture.sv
// VGA link sink: locks to the sync timing, recovers active-pixel x/y,
// and produces a per-frame RGB checksum plus a saturating timing-error count.
module vga_capture #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hSync,
    input  logic        vSync,
    input  logic [11:0] rgb_in,
    output logic        locked,
    output logic        pix_valid,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic [11:0] pix_rgb,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [7:0]  err_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_LIMIT = 10'(H_TOTAL + 15);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0] CNT_MAX = 10'h3ff;

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        h_prev_q, h_prev_d;
    logic        v_prev_q, v_prev_d;
    logic        vpend_q, vpend_d;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [15:0] acc_q, acc_d;
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [11:0] rgb_q, rgb_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_sum_q, frame_sum_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        h_edge, v_edge, frame_start, in_check, timing_err, active;
    logic [9:0]  h_cnt_nxt, v_cnt_nxt, y_full;

    assign h_edge      = pix_en && (hSync == SYNC_POL) && (h_prev_q != SYNC_POL);
    assign v_edge      = pix_en && (vSync == SYNC_POL) && (v_prev_q != SYNC_POL);
    assign frame_start = h_edge && (vpend_q || v_edge);
    assign in_check    = (state_q != ST_SEARCH);

    // Position of the sample being taken now; active-window and overflow tests use it.
    assign h_cnt_nxt = h_edge ? 10'd0 : ((h_cnt_q == CNT_MAX) ? h_cnt_q : h_cnt_q + 10'd1);
    assign v_cnt_nxt = frame_start ? 10'd0 :
                       ((h_edge && v_cnt_q != CNT_MAX) ? v_cnt_q + 10'd1 : v_cnt_q);
    assign y_full    = v_cnt_nxt - V_START;

    assign timing_err = pix_en && in_check &&
                        ((h_edge && h_cnt_q != H_LAST) ||
                         (!h_edge && h_cnt_nxt == H_LIMIT) ||
                         (frame_start && v_cnt_q != V_LAST));

    assign active = (h_cnt_nxt >= H_START) && (h_cnt_nxt < H_END) &&
                    (v_cnt_nxt >= V_START) && (v_cnt_nxt < V_END);

    always_comb begin
        state_d      = state_q;
        h_prev_d     = h_prev_q;
        v_prev_d     = v_prev_q;
        vpend_d      = vpend_q;
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        acc_d        = acc_q;
        pix_valid_d  = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        rgb_d        = rgb_q;
        frame_done_d = 1'b0;
        frame_sum_d  = frame_sum_q;
        err_count_d  = err_count_q;

        if (pix_en) begin
            h_prev_d = hSync;
            v_prev_d = vSync;
            h_cnt_d  = h_cnt_nxt;
            v_cnt_d  = v_cnt_nxt;
            vpend_d  = h_edge ? 1'b0 : (vpend_q || v_edge);

            if (timing_err) begin
                state_d = ST_SEARCH;
                acc_d   = 16'd0;
                if (err_count_q != 8'hff) begin
                    err_count_d = err_count_q + 8'd1;
                end
            end else begin
                if (frame_start) begin
                    acc_d = 16'd0;
                    case (state_q)
                        ST_SEARCH: state_d = ST_CHECK;
                        ST_CHECK:  state_d = ST_LOCKED;
                        ST_LOCKED: begin
                            frame_sum_d  = acc_q;
                            frame_done_d = 1'b1;
                        end
                        default:   state_d = ST_SEARCH;
                    endcase
                end else if (active && in_check) begin
                    acc_d = acc_q + {4'b0, rgb_in};
                end

                if (active && state_q == ST_LOCKED) begin
                    pix_valid_d = 1'b1;
                    x_d         = h_cnt_nxt - H_START;
                    y_d         = y_full[8:0];
                    rgb_d       = rgb_in;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_SEARCH;
            h_prev_q     <= 1'b0;
            v_prev_q     <= 1'b0;
            vpend_q      <= 1'b0;
            h_cnt_q      <= 10'd0;
            v_cnt_q      <= 10'd0;
            acc_q        <= 16'd0;
            pix_valid_q  <= 1'b0;
            x_q          <= 10'd0;
            y_q          <= 9'd0;
            rgb_q        <= 12'd0;
            frame_done_q <= 1'b0;
            frame_sum_q  <= 16'd0;
            err_count_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            h_prev_q     <= h_prev_d;
            v_prev_q     <= v_prev_d;
            vpend_q      <= vpend_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            acc_q        <= acc_d;
            pix_valid_q  <= pix_valid_d;
            x_q          <= x_d;
            y_q          <= y_d;
            rgb_q        <= rgb_d;
            frame_done_q <= frame_done_d;
            frame_sum_q  <= frame_sum_d;
            err_count_q  <= err_count_d;
        end
    end

    assign locked     = (state_q == ST_LOCKED);
    assign pix_valid  = pix_valid_q;
    assign x          = x_q;
    assign y          = y_q;
    assign pix_rgb    = rgb_q;
    assign frame_done = frame_done_q;
    assign frame_sum  = frame_sum_q;
    assign err_count  = err_count_q;
endmodule
